mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle main control FSM for the MIPS-subset CPU.
- Decodes the latched instruction opcode and sequences the datapath through fetch, decode, execute, memory and write-back.
- Drives RegWrite and the write-address/write-data selects (RegDst, MemtoReg) directly into the register file, and supplies every other datapath enable and mux select.

Parameters:
- ST_W, 4, width of the state register and of the state debug output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- op  input  6  opcode, inst[31:26], from the instruction register.
- zero  input  1  ALU zero flag (combinational from the ALU).
- PCWrite  output  1  unconditional PC write enable.
- PCWriteCond  output  1  conditional PC write enable for branches.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load enable.
- MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  register write address select: 0 = inst[20:16], 1 = inst[15:11].
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A input select: 0 = PC, 1 = A register.
- ALUSrcB  output  2  ALU B input select: 0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- ALUOp  output  2  ALU operation: 0 = add, 1 = sub, 2 = use funct field.
- PCSource  output  2  PC source select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- Done  output  1  high during the final cycle of each instruction.
- state  output  ST_W  current state, for debug.

Behaviour:
- Reset:
  - Asynchronous; state goes to FETCH (0) immediately when resetn falls.
  - While resetn is low, every enable and strobe is forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, Done. Selects are don't-care.
  - After resetn rises, the first clock edge begins FETCH.
  - Reset mid-instruction abandons the instruction with no further writes.
- Outputs are Moore: a function of state only, except the gating by resetn. All signals not listed for a state are 0.
- States and outputs:
  - FETCH (0): MemRead, IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0, PCWrite.
  - DECODE (1): ALUSrcA=0, ALUSrcB=3, ALUOp=0 (computes the branch target into ALUOut).
  - MEMADR (2): ALUSrcA=1, ALUSrcB=2, ALUOp=0.
  - MEMRD (3): MemRead, IorD=1.
  - MEMWB (4): RegWrite, RegDst=0, MemtoReg=1, Done.
  - MEMWR (5): MemWrite, IorD=1, Done.
  - RTEX (6): ALUSrcA=1, ALUSrcB=0, ALUOp=2.
  - RTWB (7): RegWrite, RegDst=1, MemtoReg=0, Done.
  - BEQ (8): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond, PCSource=1, Done.
  - JUMP (9): PCWrite, PCSource=2, Done.
  - ADDIEX (10): ALUSrcA=1, ALUSrcB=2, ALUOp=0.
  - ADDIWB (11): RegWrite, RegDst=0, MemtoReg=0, Done.
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatches on op: 0x00 -> RTEX; 0x23 (lw) or 0x2B (sw) -> MEMADR; 0x04 -> BEQ; 0x02 -> JUMP; 0x08 -> ADDIEX; any other op -> FETCH.
  - An illegal op costs 2 cycles with no register or memory write, and Done stays 0.
  - MEMADR -> MEMRD if op == 0x23, else MEMWR.
  - MEMRD -> MEMWB; RTEX -> RTWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTWB, BEQ, JUMP and ADDIWB each -> FETCH.
  - Unused encodings 12–15 -> FETCH with all enables 0.
- Latency in cycles including fetch: lw 5; sw, R-type and addi 4; beq and j 3.
- PC commit condition: the PC is written when PCWrite | (PCWriteCond & zero). The combining gate lives in the datapath, not in this block.
- RegWrite is high for exactly one cycle per register-writing instruction and is never high in the same cycle as MemWrite.
- RegWrite is issued for every register-writing instruction, including destination $0; the register file discards writes to $0.

Optional Feature:
- Macro MC_BNE_EN.
- When defined:
  - Adds state BNE (12): same outputs as BEQ.
  - Adds output port BranchNe (1 bit), high only in BNE, reset 0.
  - DECODE sends op 0x05 to BNE; BNE -> FETCH.
  - The datapath commits the PC when PCWriteCond & (zero ^ BranchNe).
- When not defined:
  - Op 0x05 is illegal (DECODE -> FETCH).
  - The BranchNe port does not exist.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release → state=0 and all enables 0 during reset; first edge after release gives state=1 with IRWrite, PCWrite and MemRead high only in the preceding cycle.
- lw (op=0x23) → state sequence 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 and RegDst=0 only in state 4; Done high once.
- R-type (op=0x00) then sw (op=0x2B) back to back → R-type visits 6,7 with RegDst=1 in 7; sw visits 2,5 with MemWrite=1 and RegWrite=0 throughout; 8 cycles total.
- beq (op=0x04) with zero=1, then again with zero=0 → state 8 asserts PCWriteCond=1 and PCSource=1 both times; no RegWrite or MemWrite; 3 cycles each.
- Illegal op=0x3F, then addi (op=0x08) → illegal goes 0,1,0 with Done never high; addi goes 0,1,10,11 with RegWrite=1 and MemtoReg=0 in state 11.
- resetn pulsed low during MEMRD of lw → state 0 asynchronously; no RegWrite ever issued for that lw. With MC_BNE_EN: op=0x05 → state 12 with BranchNe=1.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multicycle main control FSM (fetch/decode/execute/mem/writeback) for the MIPS-subset CPU.
// Define MC_BNE_EN to add the BNE state and the BranchNe output.
module mc_control #(
    parameter int unsigned ST_W = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [5:0]      op,
    input  logic            zero,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            Done,
`ifdef MC_BNE_EN
    output logic            BranchNe,
`endif
    output logic [ST_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = ST_W'(0),
        ST_DECODE = ST_W'(1),
        ST_MEMADR = ST_W'(2),
        ST_MEMRD  = ST_W'(3),
        ST_MEMWB  = ST_W'(4),
        ST_MEMWR  = ST_W'(5),
        ST_RTEX   = ST_W'(6),
        ST_RTWB   = ST_W'(7),
        ST_BEQ    = ST_W'(8),
        ST_JUMP   = ST_W'(9),
        ST_ADDIEX = ST_W'(10),
        ST_ADDIWB = ST_W'(11),
        ST_BNE    = ST_W'(12)
    } state_e;

    state_e state_q;
    state_e state_d;

    // The ALU zero flag is combined with PCWriteCond in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = ST_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        PCSource    = 2'd0;
        Done        = 1'b0;
`ifdef MC_BNE_EN
        BranchNe    = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'd1;
                PCWrite = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSrcB = 2'd3;
                case (op)
                    OP_RTYPE:     state_d = ST_RTEX;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDIEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = ST_BNE;
`endif
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                Done     = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Done     = 1'b1;
            end
            ST_RTEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd2;
                state_d = ST_RTWB;
            end
            ST_RTWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                Done     = 1'b1;
            end
            ST_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                Done        = 1'b1;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
                Done     = 1'b1;
            end
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                state_d = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                RegWrite = 1'b1;
                Done     = 1'b1;
            end
`ifdef MC_BNE_EN
            ST_BNE: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                Done        = 1'b1;
                BranchNe    = 1'b1;
            end
`endif
            default: ;
        endcase
        // Enables and strobes are held low for the whole time reset is asserted.
        if (!resetn) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            Done        = 1'b0;
`ifdef MC_BNE_EN
            BranchNe    = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed plus random instruction streams for mc_control, checked against an instruction-level model.
module tb_mc_control;

    localparam int unsigned ST_W = 4;

    logic            clk;
    logic            resetn;
    logic [5:0]      op;
    logic            zero;
    logic            PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic            MemtoReg, RegDst, RegWrite, ALUSrcA, Done;
    logic [1:0]      ALUSrcB, ALUOp, PCSource;
    logic [ST_W-1:0] state;
    logic            bne_c;
`ifdef MC_BNE_EN
    logic            BranchNe;
    assign bne_c = BranchNe;
`else
    assign bne_c = 1'b0;
`endif

    mc_control #(.ST_W(ST_W)) dut (
        .clk(clk), .resetn(resetn), .op(op), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Done(Done),
`ifdef MC_BNE_EN
        .BranchNe(BranchNe),
`endif
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    int exp_q[$];

    logic [16:0] obs;
    logic [6:0]  enables;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Done};
    assign enables = {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, Done};

    // Output table per state number, straight from the state/output listing.
    function automatic logic [16:0] exp_out(input int s);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, dn;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, dn} = 11'b0;
        asb = 2'd0; aop = 2'd0; pcs = 2'd0;
        case (s)
            0:  begin mrd = 1'b1; irw = 1'b1; asb = 2'd1; pcw = 1'b1; end
            1:  asb = 2'd3;
            2:  begin asa = 1'b1; asb = 2'd2; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; dn = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'd2; end
            7:  begin rw = 1'b1; rdst = 1'b1; dn = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'd1; pcwc = 1'b1; pcs = 2'd1; dn = 1'b1; end
            9:  begin pcw = 1'b1; pcs = 2'd2; dn = 1'b1; end
            10: begin asa = 1'b1; asb = 2'd2; end
            11: begin rw = 1'b1; dn = 1'b1; end
`ifdef MC_BNE_EN
            12: begin asa = 1'b1; aop = 2'd1; pcwc = 1'b1; pcs = 2'd1; dn = 1'b1; end
`endif
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, dn};
    endfunction

    // Expected state trace of one instruction, fetch through its last cycle.
    function automatic void model_seq(input logic [5:0] o);
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(1);
        case (o)
            6'h23: begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
            6'h2B: begin exp_q.push_back(2); exp_q.push_back(5); end
            6'h00: begin exp_q.push_back(6); exp_q.push_back(7); end
            6'h04: exp_q.push_back(8);
            6'h02: exp_q.push_back(9);
            6'h08: begin exp_q.push_back(10); exp_q.push_back(11); end
`ifdef MC_BNE_EN
            6'h05: exp_q.push_back(12);
`endif
            default: ;
        endcase
    endfunction

    task automatic check_cycle(input int s);
        logic [16:0] e;
        e = exp_out(s);
        n_cmp++;
        assert (state === ST_W'(s))
        else begin n_fail++; $error("FAIL state: observed %0d expected %0d", state, s); end
        n_cmp++;
        assert (obs === e)
        else begin n_fail++; $error("FAIL outputs_st%0d: observed %h expected %h", s, obs, e); end
`ifdef MC_BNE_EN
        n_cmp++;
        assert (BranchNe === (s == 12))
        else begin n_fail++; $error("FAIL branchne_st%0d: observed %b expected %b", s, BranchNe, (s == 12)); end
`endif
    endtask

    task automatic check_reset_quiet(input string tag);
        n_cmp++;
        assert (state === ST_W'(0))
        else begin n_fail++; $error("FAIL %s_state: observed %0d expected 0", tag, state); end
        n_cmp++;
        assert (enables === 7'b0)
        else begin n_fail++; $error("FAIL %s_enables: observed %b expected 0000000", tag, enables); end
    endtask

    // Runs one instruction from its fetch cycle and checks per-cycle and per-instruction results.
    task automatic run_instr(input logic [5:0] o, input logic z);
        int rw_n, mw_n, dn_n, pc_n, ov_n;
        int e_rw, e_mw, e_dn, e_pc;
        logic legal;
        model_seq(o);
        rw_n = 0; mw_n = 0; dn_n = 0; pc_n = 0; ov_n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                op   = o;
                zero = z;
            end
            check_cycle(exp_q[i]);
            rw_n += int'(RegWrite);
            mw_n += int'(MemWrite);
            dn_n += int'(Done);
            ov_n += int'(RegWrite & MemWrite);
            pc_n += int'(PCWrite | (PCWriteCond & (zero ^ bne_c)));
        end
        legal = (o == 6'h00) || (o == 6'h23) || (o == 6'h2B) || (o == 6'h04) ||
                (o == 6'h02) || (o == 6'h08);
`ifdef MC_BNE_EN
        legal = legal || (o == 6'h05);
`endif
        e_rw = int'((o == 6'h00) || (o == 6'h23) || (o == 6'h08));
        e_mw = int'(o == 6'h2B);
        e_dn = int'(legal);
        e_pc = 1 + int'(o == 6'h02) + int'((o == 6'h04) && z);
`ifdef MC_BNE_EN
        e_pc += int'((o == 6'h05) && !z);
`endif
        n_cmp++;
        assert (rw_n == e_rw)
        else begin n_fail++; $error("FAIL regwrite_count op%h: observed %0d expected %0d", o, rw_n, e_rw); end
        n_cmp++;
        assert (mw_n == e_mw)
        else begin n_fail++; $error("FAIL memwrite_count op%h: observed %0d expected %0d", o, mw_n, e_mw); end
        n_cmp++;
        assert (dn_n == e_dn)
        else begin n_fail++; $error("FAIL done_count op%h: observed %0d expected %0d", o, dn_n, e_dn); end
        n_cmp++;
        assert (pc_n == e_pc)
        else begin n_fail++; $error("FAIL pc_commits op%h z%b: observed %0d expected %0d", o, z, pc_n, e_pc); end
        n_cmp++;
        assert (ov_n == 0)
        else begin n_fail++; $error("FAIL rw_mw_overlap op%h: observed %0d expected 0", o, ov_n); end
    endtask

    initial begin
        logic [5:0] rop;
        logic       rz;
        n_cmp  = 0;
        n_fail = 0;
        resetn = 1'b0;
        op     = 6'h00;
        zero   = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check_reset_quiet("reset");
        end
        @(posedge clk);
        #2 resetn = 1'b1;

        run_instr(6'h23, 1'b0);
        run_instr(6'h00, 1'b0);
        run_instr(6'h2B, 1'b1);
        run_instr(6'h04, 1'b1);
        run_instr(6'h04, 1'b0);
        run_instr(6'h3F, 1'b0);
        run_instr(6'h08, 1'b1);
        run_instr(6'h02, 1'b0);
        run_instr(6'h05, 1'b0);
        run_instr(6'h05, 1'b1);

        // lw abandoned by reset while reading memory.
        @(negedge clk);
        op   = 6'h23;
        zero = 1'b0;
        check_cycle(0);
        @(negedge clk);
        check_cycle(1);
        @(negedge clk);
        check_cycle(2);
        @(negedge clk);
        check_cycle(3);
        #1 resetn = 1'b0;
        #1 check_reset_quiet("abort_async");
        repeat (2) begin
            @(negedge clk);
            check_reset_quiet("abort_hold");
        end
        @(posedge clk);
        #2 resetn = 1'b1;
        run_instr(6'h00, 1'b1);

        repeat (40) begin
            case ($urandom_range(0, 7))
                0: rop = 6'h00;
                1: rop = 6'h23;
                2: rop = 6'h2B;
                3: rop = 6'h04;
                4: rop = 6'h02;
                5: rop = 6'h08;
                6: rop = 6'h05;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            rz = 1'($urandom_range(0, 1));
            run_instr(rop, rz);
        end

        @(negedge clk);
        check_cycle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
